// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, state type and PC helper for the IF stage
package fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    FETCH_REQ  = 1'b0,
    FETCH_HOLD = 1'b1
  } fetchStateT;

  function automatic logic [31:0] seqPc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry instruction buffer and REQ/HOLD fetch state
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic [31:0] loadData,
  output logic        full,
  output logic [31:0] data
);

  fetchStateT state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= FETCH_REQ;
      data  <= 32'h0;
    end else begin
      case (state)
        FETCH_REQ: begin
          if (load) begin
            state <= FETCH_HOLD;
            data  <= loadData;
          end
        end
        FETCH_HOLD: begin
          if (drain) state <= FETCH_REQ;
        end
      endcase
    end
  end

  assign full = (state == FETCH_HOLD);

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, variable-latency imem port and IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imemRequest,
  output logic [31:0] imemAddress,
  input  logic        imemReady,
  input  logic [31:0] imemReadData,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] jumpOrBranchPc,
  output logic [31:0] pc_4,
  output logic [31:0] instruction,
  output logic [31:0] fetchPc
);

  logic        redirectPending;
  logic [31:0] redirectTarget;
  logic        holding;
  logic [31:0] bufferedInstr;

  logic        redirect;
  logic [31:0] targetPc;
  logic [31:0] nextPc;
  logic [31:0] fetchPcPlus4;

  logic        acceptNow;
  logic        missNow;
  logic        loadNow;
  logic        drainNow;

  // A redirect seen during a stall is dropped; decode re-presents the branch later.
  assign redirect     = redirectPending | (shouldJumpOrBranch & ~shouldStall);
  assign targetPc     = redirectPending ? redirectTarget : jumpOrBranchPc;
  assign fetchPcPlus4 = seqPc(fetchPc);
  assign nextPc       = redirect ? targetPc : fetchPcPlus4;

  assign acceptNow = ~holding & imemReady & ~shouldStall;
  assign missNow   = ~holding & ~imemReady & ~shouldStall;
  assign loadNow   = ~holding & imemReady & shouldStall;
  assign drainNow  = holding & ~shouldStall;

  fetch_skid_buffer skid (
    .clock    (clock),
    .reset    (reset),
    .load     (loadNow),
    .drain    (drainNow),
    .loadData (imemReadData),
    .full     (holding),
    .data     (bufferedInstr)
  );

  // Request drops the moment reset asserts so the memory sees the access abandoned.
  assign imemRequest = reset & ~holding;
  assign imemAddress = fetchPc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetchPc         <= RESET_PC;
      redirectPending <= 1'b0;
      redirectTarget  <= 32'h0;
      pc_4            <= 32'h0;
      instruction     <= NOP_INSTR;
    end else begin
      if (acceptNow) begin
        pc_4            <= fetchPcPlus4;
        instruction     <= imemReadData;
        fetchPc         <= nextPc;
        redirectPending <= 1'b0;
      end else if (drainNow) begin
        pc_4            <= fetchPcPlus4;
        instruction     <= bufferedInstr;
        fetchPc         <= nextPc;
        redirectPending <= 1'b0;
      end else if (missNow) begin
        pc_4        <= 32'h0;
        instruction <= NOP_INSTR;
        if (shouldJumpOrBranch) begin
          redirectPending <= 1'b1;
          redirectTarget  <= jumpOrBranchPc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imemRequest;
  logic [31:0] imemAddress;
  logic        imemReady = 1'b0;
  logic [31:0] imemReadData = 32'h0;
  logic        shouldStall = 1'b0;
  logic        shouldJumpOrBranch = 1'b0;
  logic [31:0] jumpOrBranchPc = 32'h0;
  logic [31:0] pc_4;
  logic [31:0] instruction;
  logic [31:0] fetchPc;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(32'h0)) dut (
    .clock              (clock),
    .reset              (reset),
    .imemRequest        (imemRequest),
    .imemAddress        (imemAddress),
    .imemReady          (imemReady),
    .imemReadData       (imemReadData),
    .shouldStall        (shouldStall),
    .shouldJumpOrBranch (shouldJumpOrBranch),
    .jumpOrBranchPc     (jumpOrBranchPc),
    .pc_4               (pc_4),
    .instruction        (instruction),
    .fetchPc            (fetchPc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ready;
    logic [31:0] rdata;
    logic        stall;
    logic        br;
    logic [31:0] brPc;
    logic        expReq;
    logic [31:0] expAddr;
    logic [31:0] expPc4;
    logic [31:0] expInstr;
  } vecT;

  vecT vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic r, input logic [31:0] d, input logic s, input logic b,
                        input logic [31:0] bp, input logic eq, input logic [31:0] ea,
                        input logic [31:0] ep, input logic [31:0] ei);
    vecT v;
    v.ready = r; v.rdata = d; v.stall = s; v.br = b; v.brPc = bp;
    v.expReq = eq; v.expAddr = ea; v.expPc4 = ep; v.expInstr = ei;
    vecs.push_back(v);
  endtask

  initial begin
    // zero-wait stream
    addVec(1, 32'h0040_0000, 0, 0, 0, 1, 32'h0040_0000, 32'h0040_0004, 32'h0040_0000);
    addVec(1, 32'h0040_0004, 0, 0, 0, 1, 32'h0040_0004, 32'h0040_0008, 32'h0040_0004);
    addVec(1, 32'h0040_0008, 0, 0, 0, 1, 32'h0040_0008, 32'h0040_000C, 32'h0040_0008);
    // three wait states then the word
    addVec(0, 32'hDEAD_BEEF, 0, 0, 0, 1, 32'h0040_000C, 32'h0, 32'h0);
    addVec(0, 32'hDEAD_BEEF, 0, 0, 0, 1, 32'h0040_000C, 32'h0, 32'h0);
    addVec(0, 32'hDEAD_BEEF, 0, 0, 0, 1, 32'h0040_000C, 32'h0, 32'h0);
    addVec(1, 32'h0040_000C, 0, 0, 0, 1, 32'h0040_000C, 32'h0040_0010, 32'h0040_000C);
    // stall on response -> HOLD, then drain
    addVec(1, 32'h0040_0010, 1, 0, 0, 1, 32'h0040_0010, 32'h0040_0010, 32'h0040_000C);
    addVec(0, 32'h1111_1111, 1, 0, 0, 0, 32'h0040_0010, 32'h0040_0010, 32'h0040_000C);
    addVec(0, 32'h2222_2222, 0, 0, 0, 0, 32'h0040_0010, 32'h0040_0014, 32'h0040_0010);
    addVec(1, 32'h0040_0014, 0, 0, 0, 1, 32'h0040_0014, 32'h0040_0018, 32'h0040_0014);
    // stall without response, branch ignored while stalled, honoured after
    addVec(0, 32'h3333_3333, 1, 0, 0, 1, 32'h0040_0018, 32'h0040_0018, 32'h0040_0014);
    addVec(0, 32'h3333_3333, 1, 1, 32'h0050_0000, 1, 32'h0040_0018, 32'h0040_0018, 32'h0040_0014);
    addVec(1, 32'h0040_0018, 0, 1, 32'h0050_0000, 1, 32'h0040_0018, 32'h0040_001C, 32'h0040_0018);
    addVec(1, 32'h0050_0000, 0, 0, 0, 1, 32'h0050_0000, 32'h0050_0004, 32'h0050_0000);
    // branch during HOLD ignored, honoured on drain
    addVec(1, 32'h0050_0004, 1, 1, 32'h0060_0000, 1, 32'h0050_0004, 32'h0050_0004, 32'h0050_0000);
    addVec(0, 32'h4444_4444, 1, 1, 32'h0060_0000, 0, 32'h0050_0004, 32'h0050_0004, 32'h0050_0000);
    addVec(0, 32'h4444_4444, 0, 1, 32'h0060_0000, 0, 32'h0050_0004, 32'h0050_0008, 32'h0050_0004);
    addVec(1, 32'h0060_0000, 0, 0, 0, 1, 32'h0060_0000, 32'h0060_0004, 32'h0060_0000);
    // walk to 0x100, branch there with a slow delay slot
    addVec(1, 32'h0060_0004, 0, 1, 32'h0000_00FC, 1, 32'h0060_0004, 32'h0060_0008, 32'h0060_0004);
    addVec(1, 32'h0000_00FC, 0, 0, 0, 1, 32'h0000_00FC, 32'h0000_0100, 32'h0000_00FC);
    addVec(1, 32'h0000_0100, 0, 0, 0, 1, 32'h0000_0100, 32'h0000_0104, 32'h0000_0100);
    addVec(0, 32'h5555_5555, 0, 1, 32'h0000_0200, 1, 32'h0000_0104, 32'h0, 32'h0);
    addVec(0, 32'h5555_5555, 0, 0, 0, 1, 32'h0000_0104, 32'h0, 32'h0);
    addVec(1, 32'h0000_0104, 0, 0, 0, 1, 32'h0000_0104, 32'h0000_0108, 32'h0000_0104);
    addVec(1, 32'h0000_0200, 0, 0, 0, 1, 32'h0000_0200, 32'h0000_0204, 32'h0000_0200);
    // PC wrap at 2^32
    addVec(1, 32'h0000_0204, 0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0204, 32'h0000_0208, 32'h0000_0204);
    addVec(1, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC);
    addVec(1, 32'h0000_0000, 0, 0, 0, 1, 32'h0000_0000, 32'h0000_0004, 32'h0000_0000);

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset imemRequest", {31'h0, imemRequest}, 32'h0);
    check("reset imemAddress", imemAddress, RPC);
    check("reset instruction", instruction, 32'h0);
    check("reset pc_4", pc_4, 32'h0);
    check("reset fetchPc", fetchPc, RPC);

    @(negedge clock);
    reset = 1'b1;
    #1;
    check("release imemRequest", {31'h0, imemRequest}, 32'h1);

    foreach (vecs[i]) begin
      @(negedge clock);
      imemReady          = vecs[i].ready;
      imemReadData       = vecs[i].rdata;
      shouldStall        = vecs[i].stall;
      shouldJumpOrBranch = vecs[i].br;
      jumpOrBranchPc     = vecs[i].brPc;
      #1;
      check($sformatf("v%0d imemRequest", i), {31'h0, imemRequest}, {31'h0, vecs[i].expReq});
      check($sformatf("v%0d imemAddress", i), imemAddress, vecs[i].expAddr);
      @(posedge clock);
      #1;
      check($sformatf("v%0d pc_4", i), pc_4, vecs[i].expPc4);
      check($sformatf("v%0d instruction", i), instruction, vecs[i].expInstr);
    end

    // async reset in the middle of a wait state
    @(negedge clock);
    imemReady = 1'b0;
    shouldStall = 1'b0;
    shouldJumpOrBranch = 1'b0;
    @(posedge clock);
    #2;
    check("midwait imemRequest", {31'h0, imemRequest}, 32'h1);
    reset = 1'b0;
    #1;
    check("async imemRequest", {31'h0, imemRequest}, 32'h0);
    check("async imemAddress", imemAddress, RPC);
    check("async instruction", instruction, 32'h0);
    check("async pc_4", pc_4, 32'h0);

    @(negedge clock);
    reset = 1'b1;
    imemReady = 1'b1;
    imemReadData = 32'hCAFE_0001;
    #1;
    check("restart imemRequest", {31'h0, imemRequest}, 32'h1);
    check("restart imemAddress", imemAddress, RPC);
    @(posedge clock);
    #1;
    check("restart pc_4", pc_4, RPC + 32'd4);
    check("restart instruction", instruction, 32'hCAFE_0001);
    check("restart fetchPc", fetchPc, RPC + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
